// File: rtl/pu_sched_pkg.sv
// Shared constants for the process-unit scheduler: FSM state codes and default sizing.
package pu_sched_pkg;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_LAUNCH = 3'd1;
  localparam logic [2:0] ST_WAIT   = 3'd2;
  localparam logic [2:0] ST_DRAIN  = 3'd3;
  localparam logic [2:0] ST_RESP   = 3'd4;

  localparam int NREQ_DEF    = 4;
  localparam int DW_DEF      = 8;
  localparam int RW_DEF      = 16;
  localparam int TIMEOUT_DEF = 15;

endpackage

// File: rtl/pu_scheduler_if.sv
// Requester-side and process-unit-side signals of the scheduler.
// The master modport is the scheduler's view and the slave modport is the environment's view.
interface pu_scheduler_if
  import pu_sched_pkg::*;
#(
  parameter int NREQ = NREQ_DEF,
  parameter int DW   = DW_DEF,
  parameter int RW   = RW_DEF
) ();

  logic [NREQ-1:0]    req;
  logic [NREQ*DW-1:0] x_in;
  logic [NREQ*DW-1:0] w_in;
  logic [NREQ-1:0]    gnt;
  logic [NREQ-1:0]    rsp_valid;
  logic [RW-1:0]      rsp_data;
  logic               rsp_err;
  logic               pu_start;
  logic [DW-1:0]      pu_x;
  logic [DW-1:0]      pu_w;
  logic [RW-1:0]      pu_y;
  logic               pu_done;

  modport master (
    input  req, x_in, w_in, pu_y, pu_done,
    output gnt, rsp_valid, rsp_data, rsp_err, pu_start, pu_x, pu_w
  );

  modport slave (
    output req, x_in, w_in, pu_y, pu_done,
    input  gnt, rsp_valid, rsp_data, rsp_err, pu_start, pu_x, pu_w
  );

endinterface

// File: rtl/pu_scheduler_rr_arbiter.sv
// Combinational round-robin pick: the lowest requesting index at or after ptr wins.
// Zero latency; gnt is all-zero and idx is 0 when nothing requests.
module rr_arbiter #(
  parameter int NREQ = 4
) (
  input  logic [NREQ-1:0]         req,
  input  logic [$clog2(NREQ)-1:0] ptr,
  output logic [NREQ-1:0]         gnt,
  output logic [$clog2(NREQ)-1:0] idx
);

  localparam int IW = $clog2(NREQ);

  logic          found;
  logic [IW:0]   sum;
  logic [IW-1:0] cand;

  always_comb begin
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    sum   = '0;
    cand  = '0;
    for (int k = 0; k < NREQ; k++) begin
      // ptr + k stays below 2*NREQ, so a single subtraction wraps it
      sum = {1'b0, ptr} + (IW+1)'(k);
      if (sum >= (IW+1)'(NREQ)) begin
        sum = sum - (IW+1)'(NREQ);
      end
      cand = sum[IW-1:0];
      if (!found && req[cand]) begin
        found     = 1'b1;
        gnt[cand] = 1'b1;
        idx       = cand;
      end
    end
  end

endmodule

// File: rtl/pu_scheduler.sv
// Shares one start/done process unit among NREQ round-robin requesters.
// Response arrives 8 cycles after the request is seen, with a timeout abort if done never comes.
module pu_scheduler
  import pu_sched_pkg::*;
#(
  parameter int NREQ    = NREQ_DEF,
  parameter int DW      = DW_DEF,
  parameter int RW      = RW_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic           clk,
  input  logic           rst_n,
  pu_scheduler_if.master bus,
  output logic           busy
);

  localparam int IW = $clog2(NREQ);
  localparam int CW = $clog2(TIMEOUT);

  logic [2:0]      state_q,     state_d;
  logic [IW-1:0]   rr_ptr_q,    rr_ptr_d;
  logic [IW-1:0]   idx_q,       idx_d;
  logic [CW-1:0]   cnt_q,       cnt_d;
  logic [DW-1:0]   x_q,         x_d;
  logic [DW-1:0]   w_q,         w_d;
  logic [RW-1:0]   result_q,    result_d;
  logic [RW-1:0]   rsp_data_q,  rsp_data_d;
  logic            err_q,       err_d;
  logic            rsp_err_q,   rsp_err_d;
  logic            pu_start_q,  pu_start_d;
  logic            busy_q,      busy_d;
  logic [NREQ-1:0] gnt_q,       gnt_d;
  logic [NREQ-1:0] rsp_valid_q, rsp_valid_d;

  logic [NREQ-1:0] arb_gnt;
  logic [IW-1:0]   arb_idx;

  rr_arbiter #(.NREQ(NREQ)) u_arb (
    .req (bus.req),
    .ptr (rr_ptr_q),
    .gnt (arb_gnt),
    .idx (arb_idx)
  );

  // Outputs are registered: each *_d is the value for the state being entered.
  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    idx_d       = idx_q;
    cnt_d       = cnt_q;
    x_d         = x_q;
    w_d         = w_q;
    result_d    = result_q;
    rsp_data_d  = rsp_data_q;
    err_d       = err_q;
    gnt_d       = gnt_q;
    rsp_err_d   = 1'b0;
    pu_start_d  = 1'b0;
    rsp_valid_d = '0;

    case (state_q)
      ST_IDLE: begin
        // A done still high here belongs to an op cut short by reset; let it clear first.
        if (|bus.req && !bus.pu_done) begin
          state_d    = ST_LAUNCH;
          idx_d      = arb_idx;
          gnt_d      = arb_gnt;
          x_d        = bus.x_in[arb_idx*DW +: DW];
          w_d        = bus.w_in[arb_idx*DW +: DW];
          pu_start_d = 1'b1;
        end
      end
      ST_LAUNCH: begin
        state_d = ST_WAIT;
        cnt_d   = '0;
      end
      ST_WAIT: begin
        if (bus.pu_done) begin
          result_d = bus.pu_y;
          state_d  = ST_DRAIN;
        end else if (cnt_q == CW'(TIMEOUT - 1)) begin
          err_d       = 1'b1;
          result_d    = '0;
          state_d     = ST_RESP;
          rsp_valid_d = gnt_q;
          rsp_data_d  = '0;
          rsp_err_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      ST_DRAIN: begin
        if (!bus.pu_done) begin
          state_d     = ST_RESP;
          rsp_valid_d = gnt_q;
          rsp_data_d  = result_q;
          rsp_err_d   = err_q;
        end
      end
      ST_RESP: begin
        state_d  = ST_IDLE;
        rr_ptr_d = (idx_q == IW'(NREQ - 1)) ? '0 : idx_q + IW'(1);
        err_d    = 1'b0;
        gnt_d    = '0;
      end
      default: begin
        state_d = ST_IDLE;
        gnt_d   = '0;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      rr_ptr_q    <= '0;
      idx_q       <= '0;
      cnt_q       <= '0;
      x_q         <= '0;
      w_q         <= '0;
      result_q    <= '0;
      rsp_data_q  <= '0;
      err_q       <= 1'b0;
      rsp_err_q   <= 1'b0;
      pu_start_q  <= 1'b0;
      busy_q      <= 1'b0;
      gnt_q       <= '0;
      rsp_valid_q <= '0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      idx_q       <= idx_d;
      cnt_q       <= cnt_d;
      x_q         <= x_d;
      w_q         <= w_d;
      result_q    <= result_d;
      rsp_data_q  <= rsp_data_d;
      err_q       <= err_d;
      rsp_err_q   <= rsp_err_d;
      pu_start_q  <= pu_start_d;
      busy_q      <= busy_d;
      gnt_q       <= gnt_d;
      rsp_valid_q <= rsp_valid_d;
    end
  end

  assign bus.gnt       = gnt_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_data  = rsp_data_q;
  assign bus.rsp_err   = rsp_err_q;
  assign bus.pu_start  = pu_start_q;
  assign bus.pu_x      = x_q;
  assign bus.pu_w      = w_q;
  assign busy          = busy_q;

endmodule

// File: tb/tb_pu_scheduler.sv
// Bench for pu_scheduler: directed table, multi-cycle corner sequences and a randomized
// phase checked against a transaction-level round-robin model with a 2-cycle-done unit model.
module tb_pu_scheduler;
  import pu_sched_pkg::*;

  localparam int NREQ = NREQ_DEF;
  localparam int DW   = DW_DEF;
  localparam int RW   = RW_DEF;
  localparam int TO   = TIMEOUT_DEF;

  logic clk = 1'b0;
  logic rst_n;
  logic busy;

  pu_scheduler_if #(.NREQ(NREQ), .DW(DW), .RW(RW)) bus ();

  pu_scheduler #(.NREQ(NREQ), .DW(DW), .RW(RW), .TIMEOUT(TO)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus),
    .busy  (busy)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  // Unit model: 0 = done 4..5 cycles after start, 1 = never done, 2 = done forced high
  int            pu_mode    = 0;
  int            pu_s       = -100;
  logic [RW-1:0] pu_res     = '0;
  logic          prev_start = 1'b0;

  typedef struct {
    logic [NREQ-1:0] req;
    logic [DW-1:0]   x;
    logic [DW-1:0]   w;
    int              exp_idx;
    logic [RW-1:0]   exp_data;
  } vec_t;

  vec_t vecs[8];

  function automatic logic [RW-1:0] relu_mul(input logic [DW-1:0] x, input logic [DW-1:0] w);
    int p;
    p = int'($signed(x)) * int'($signed(w));
    return (p < 0) ? '0 : RW'(p);
  endfunction

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    cyc++;
    @(negedge clk);
    chk("gnt_onehot", longint'($countones(bus.gnt) <= 1), 1);
    chk("rsp_onehot", longint'($countones(bus.rsp_valid) <= 1), 1);
    chk("start_single", longint'(prev_start && bus.pu_start), 0);
    prev_start = bus.pu_start;
    if (bus.pu_start) begin
      pu_s   = cyc;
      pu_res = relu_mul(bus.pu_x, bus.pu_w);
    end
    case (pu_mode)
      1:       bus.pu_done = 1'b0;
      2:       bus.pu_done = 1'b1;
      default: bus.pu_done = (cyc == pu_s + 4) || (cyc == pu_s + 5);
    endcase
    bus.pu_y = bus.pu_done ? pu_res : RW'(32'hBEEF);
  endtask

  task automatic do_reset();
    rst_n   = 1'b0;
    bus.req = '0;
    tick();
    rst_n = 1'b1;
  endtask

  // Winner slice gets (x,w); the other slices get the complement so a wrong mux shows up.
  task automatic drive_one(input logic [NREQ-1:0] r, input int win,
                           input logic [DW-1:0] x, input logic [DW-1:0] w);
    bus.req = r;
    for (int i = 0; i < NREQ; i++) begin
      bus.x_in[i*DW +: DW] = (i == win) ? x : ~x;
      bus.w_in[i*DW +: DW] = (i == win) ? w : ~w;
    end
  endtask

  task automatic drive_all(input logic [NREQ-1:0] r);
    bus.req = r;
    for (int i = 0; i < NREQ; i++) begin
      bus.x_in[i*DW +: DW] = DW'(i + 1);
      bus.w_in[i*DW +: DW] = DW'(3);
    end
  endtask

  task automatic wait_rsp(input int budget, output int idx, output int at,
                          output logic [RW-1:0] d, output logic e, output int start_at);
    idx = -1; at = -1; start_at = -1; d = '0; e = 1'b0;
    for (int k = 0; k < budget; k++) begin
      tick();
      if (bus.pu_start && start_at < 0) start_at = cyc;
      if (bus.rsp_valid != '0) begin
        idx = $clog2(bus.rsp_valid);
        at  = cyc;
        d   = bus.rsp_data;
        e   = bus.rsp_err;
        break;
      end
    end
    if (at < 0) begin
      checks++;
      failures++;
      $display("FAIL rsp_wait: no rsp_valid within %0d cycles (cycle %0d)", budget, cyc);
    end
  endtask

  int              r_idx, r_at, r_st, c0, prev_at;
  logic [RW-1:0]   r_d;
  logic            r_e;
  int              exp_order[6];

  // Randomized-phase model state
  logic [NREQ-1:0] pending, req_prev;
  logic [DW-1:0]   px[NREQ];
  logic [DW-1:0]   pw[NREQ];
  logic            done_prev, inflight, exp_start, idle_prev;
  int              mptr, last_rsp, exp_rsp, m_idx, win;
  logic [RW-1:0]   m_data;

  initial begin
    rst_n       = 1'b0;
    bus.req     = '0;
    bus.x_in    = '0;
    bus.w_in    = '0;
    bus.pu_y    = '0;
    bus.pu_done = 1'b0;
    tick();
    tick();
    chk("rst_busy", busy, 0);
    chk("rst_gnt", bus.gnt, 0);
    chk("rst_rsp_valid", bus.rsp_valid, 0);
    chk("rst_rsp_data", bus.rsp_data, 0);
    chk("rst_rsp_err", bus.rsp_err, 0);
    chk("rst_pu_start", bus.pu_start, 0);
    chk("rst_pu_x", bus.pu_x, 0);
    chk("rst_pu_w", bus.pu_w, 0);
    rst_n = 1'b1;

    // Pointer starts at 0 and moves to winner+1 after each vector.
    vecs[0] = '{4'b0001, 8'd3,   8'd5,   0, 16'd15};
    vecs[1] = '{4'b0001, 8'hFE,  8'd7,   0, 16'd0};
    vecs[2] = '{4'b1111, 8'd10,  8'd10,  1, 16'd100};
    vecs[3] = '{4'b1001, 8'hFB,  8'hFA,  3, 16'd30};
    vecs[4] = '{4'b0110, 8'd127, 8'd127, 1, 16'd16129};
    vecs[5] = '{4'b0010, 8'h80,  8'h80,  1, 16'd16384};
    vecs[6] = '{4'b0101, 8'd1,   8'hFF,  2, 16'd0};
    vecs[7] = '{4'b0011, 8'd0,   8'd99,  0, 16'd0};

    foreach (vecs[n]) begin
      drive_one(vecs[n].req, vecs[n].exp_idx, vecs[n].x, vecs[n].w);
      c0 = cyc;
      wait_rsp(30, r_idx, r_at, r_d, r_e, r_st);
      chk($sformatf("vec%0d_idx", n), r_idx, vecs[n].exp_idx);
      chk($sformatf("vec%0d_start_cyc", n), r_st, c0 + 1);
      chk($sformatf("vec%0d_rsp_cyc", n), r_at, c0 + 8);
      chk($sformatf("vec%0d_data", n), r_d, vecs[n].exp_data);
      chk($sformatf("vec%0d_err", n), r_e, 0);
      chk($sformatf("vec%0d_gnt_at_rsp", n), bus.gnt, 1 << vecs[n].exp_idx);
      chk($sformatf("vec%0d_busy_at_rsp", n), busy, 1);
      bus.req = '0;
      tick();
      chk($sformatf("vec%0d_idle_busy", n), busy, 0);
      chk($sformatf("vec%0d_idle_gnt", n), bus.gnt, 0);
      chk($sformatf("vec%0d_data_hold", n), bus.rsp_data, vecs[n].exp_data);
    end

    // Round robin with all requesters held
    do_reset();
    drive_all(4'b1111);
    exp_order = '{0, 1, 2, 3, 0, 0};
    prev_at = 0;
    for (int k = 0; k < 5; k++) begin
      wait_rsp(30, r_idx, r_at, r_d, r_e, r_st);
      chk($sformatf("rr%0d_idx", k), r_idx, exp_order[k]);
      chk($sformatf("rr%0d_data", k), r_d, (exp_order[k] + 1) * 3);
      if (k > 0) chk($sformatf("rr%0d_spacing", k), r_at - prev_at, 9);
      prev_at = r_at;
    end
    bus.req = '0;
    tick();

    // Fairness: 0 and 2 alternate, then a late requester 1 goes ahead of 0
    do_reset();
    drive_all(4'b0101);
    exp_order = '{0, 2, 0, 1, 2, 0};
    for (int k = 0; k < 6; k++) begin
      wait_rsp(30, r_idx, r_at, r_d, r_e, r_st);
      chk($sformatf("fair%0d_idx", k), r_idx, exp_order[k]);
      if (k == 2) bus.req = 4'b0111;
    end
    bus.req = '0;
    tick();

    // Timeout: the unit never answers; pointer is 1 here so requester 2 wins
    pu_mode = 1;
    drive_one(4'b0100, 2, 8'd5, 8'd5);
    c0 = cyc;
    wait_rsp(40, r_idx, r_at, r_d, r_e, r_st);
    chk("to_idx", r_idx, 2);
    chk("to_start_cyc", r_st, c0 + 1);
    chk("to_rsp_cyc", r_at, c0 + 2 + TO);
    chk("to_err", r_e, 1);
    chk("to_data", r_d, 0);
    bus.req = '0;
    tick();
    chk("to_idle_busy", busy, 0);
    chk("to_idle_err", bus.rsp_err, 0);
    pu_mode = 0;

    // Stale done held high in IDLE blocks the launch until it drops
    pu_mode = 2;
    bus.pu_done = 1'b1;
    drive_one(4'b0001, 0, 8'd2, 8'd9);
    for (int k = 0; k < 6; k++) begin
      tick();
      chk("stale_no_start", bus.pu_start, 0);
      chk("stale_not_busy", busy, 0);
    end
    pu_mode = 0;
    bus.pu_done = 1'b0;
    c0 = cyc;
    wait_rsp(30, r_idx, r_at, r_d, r_e, r_st);
    chk("stale_start_cyc", r_st, c0 + 1);
    chk("stale_rsp_cyc", r_at, c0 + 8);
    chk("stale_data", r_d, 18);
    bus.req = '0;
    tick();

    // Reset in the middle of WAIT; the unit finishes its op on its own
    drive_one(4'b0010, 1, 8'd4, 8'd4);
    c0 = cyc;
    tick();
    chk("rmid_start", bus.pu_start, 1);
    tick();
    tick();
    rst_n   = 1'b0;
    bus.req = '0;
    tick();
    chk("rmid_busy", busy, 0);
    chk("rmid_gnt", bus.gnt, 0);
    chk("rmid_start0", bus.pu_start, 0);
    chk("rmid_rsp_valid", bus.rsp_valid, 0);
    chk("rmid_rsp_data", bus.rsp_data, 0);
    chk("rmid_pu_x", bus.pu_x, 0);
    rst_n = 1'b1;
    tick();
    bus.req = 4'b0010;
    for (int k = 0; k < 2; k++) begin
      tick();
      chk("rmid_wait_done_fall", bus.pu_start, 0);
      chk("rmid_no_rsp", bus.rsp_valid, 0);
    end
    wait_rsp(30, r_idx, r_at, r_d, r_e, r_st);
    chk("rmid_relaunch_cyc", r_st, c0 + 8);
    chk("rmid_rsp_cyc", r_at, c0 + 15);
    chk("rmid_idx", r_idx, 1);
    chk("rmid_data", r_d, 16);
    bus.req = '0;
    tick();

    // Randomized requesters against the transaction-level model
    do_reset();
    mptr = 0; inflight = 1'b0; last_rsp = cyc - 1; exp_rsp = 0; m_idx = 0; m_data = '0;
    pending = '0; req_prev = '0; done_prev = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      px[i] = '0;
      pw[i] = '0;
    end
    for (int n = 0; n < 2000; n++) begin
      tick();
      idle_prev = !inflight && (cyc - 1 > last_rsp);
      exp_start = idle_prev && (req_prev != '0) && !done_prev;
      chk("rand_start", bus.pu_start, exp_start);
      if (bus.pu_start && exp_start) begin
        win = -1;
        for (int k = 0; k < NREQ; k++) begin
          if (win < 0 && req_prev[(mptr + k) % NREQ]) win = (mptr + k) % NREQ;
        end
        chk("rand_gnt", bus.gnt, 1 << win);
        chk("rand_pu_x", bus.pu_x, px[win]);
        chk("rand_pu_w", bus.pu_w, pw[win]);
        inflight = 1'b1;
        m_idx    = win;
        m_data   = relu_mul(px[win], pw[win]);
        exp_rsp  = cyc + 7;
      end
      if (inflight && cyc == exp_rsp) begin
        chk("rand_rsp_valid", bus.rsp_valid, 1 << m_idx);
        chk("rand_rsp_data", bus.rsp_data, m_data);
        chk("rand_rsp_err", bus.rsp_err, 0);
        inflight       = 1'b0;
        last_rsp       = cyc;
        mptr           = (m_idx + 1) % NREQ;
        pending[m_idx] = 1'b0;
      end else if (bus.rsp_valid != '0) begin
        chk("rand_spurious_rsp", bus.rsp_valid, 0);
      end
      for (int i = 0; i < NREQ; i++) begin
        if (!pending[i] && $urandom_range(0, 3) == 0) begin
          pending[i] = 1'b1;
          px[i]      = DW'($urandom);
          pw[i]      = DW'($urandom);
        end
        bus.x_in[i*DW +: DW] = pending[i] ? px[i] : DW'($urandom);
        bus.w_in[i*DW +: DW] = pending[i] ? pw[i] : DW'($urandom);
      end
      bus.req   = pending;
      req_prev  = pending;
      done_prev = bus.pu_done;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pu_scheduler.md
Name: pu_scheduler

Overview:
Shares one process unit (mult/add/relu neuron, start/done handshake) among NREQ requesters. Requesters are arbitrated round-robin. The scheduler muxes the winner's operands to the unit, issues a single-cycle start pulse and waits for done. It captures the result and returns it with a one-cycle response strobe. It sits between the layer-level control and the shared process unit, and also guards against a hung unit with a timeout.

Parameters:
NREQ, 4, number of requesters (2..8)
DW, 8, operand width of x and w
RW, 16, result width from the process unit
TIMEOUT, 15, max cycles in WAIT before abort (>= 6)

Ports:
clk  input  1  system clock, all logic on posedge
rst_n  input  1  synchronous, active-low reset; one clock, reset sampled on posedge clk only
req  input  NREQ  per-requester request level, held until its rsp_valid
x_in  input  NREQ*DW  packed operands x, slice i belongs to requester i
w_in  input  NREQ*DW  packed weights w, slice i belongs to requester i
gnt  output  NREQ  one-hot grant, high from LAUNCH through RESP
rsp_valid  output  NREQ  one-cycle result strobe to granted requester
rsp_data  output  RW  captured result, valid with rsp_valid
rsp_err  output  1  high with rsp_valid when op aborted by timeout
pu_start  output  1  start pulse to process unit (exactly 1 cycle)
pu_x  output  DW  operand to process unit, stable LAUNCH..DRAIN
pu_w  output  DW  weight to process unit, stable LAUNCH..DRAIN
pu_y  input  RW  process unit result
pu_done  input  1  process unit done (high 2 cycles per op)
busy  output  1  high in any state except IDLE

Behaviour:
- Reset: state=IDLE, rr pointer=0, idx=0, count=0, captured result=0. All outputs are 0.
- Reset mid-operation aborts with no rsp_valid. The process unit is not reset and finishes on its own. The IDLE launch guard below keeps these from overlapping.
- States: IDLE, LAUNCH, WAIT, DRAIN, RESP. Registered Moore outputs.
- IDLE: if |req and pu_done==0, pick the winner by round-robin starting at the rr pointer. Latch idx, x_in[idx] and w_in[idx] into operand registers, then go to LAUNCH. Otherwise stay in IDLE.
- LAUNCH: pu_start=1 for this cycle only, gnt[idx]=1, clear count, then go to WAIT. pu_start is never high 2 consecutive cycles, because the process unit holds INIT while start is high.
- WAIT: count++. On pu_done==1 (first done cycle), capture pu_y and go to DRAIN. Otherwise, if count==TIMEOUT-1, set err and go to RESP with result=0.
- DRAIN: hold until pu_done==0, then go to RESP. This ensures the unit has returned to idle before the next launch.
- RESP: rsp_valid[idx]=1, rsp_data=result, rsp_err=err. Set rr pointer=(idx+1) mod NREQ, clear err, then go to IDLE.
- Latency with the team's process unit: req seen in IDLE at cycle 0, pu_start at cycle 1, pu_done cycles 5-6, rsp_valid at cycle 8. Back-to-back throughput is one op per 9 cycles.
- Arbitration: the lowest index at or after the rr pointer wins. A requester just served has lowest priority next round, which prevents starvation.
- req dropped mid-op: the op still completes and rsp_valid is still pulsed. The requester ignores it.
- req sampled only in IDLE. Operand changes after IDLE are ignored.
- A pu_done seen in IDLE/LAUNCH (stale) is ignored; IDLE waits for it to clear.
- rsp_data holds its last value between strobes. gnt and rsp_valid are never multi-hot.

Decomposition:
- Package pu_sched_pkg holds the state encoding constants (IDLE..RESP, 3 bits) and the default NREQ/DW/RW/TIMEOUT values.
- One sub-module, rr_arbiter (inputs req and ptr; output one-hot gnt plus binary idx), is combinational and reusable by the layer controller.
- The FSM, timeout counter and operand/result registers stay in pu_scheduler.

Test Plan:
- Single request: req=4'b0001, x_in[0]=3, w_in[0]=5, unit model returns relu(x*w)=15 -> pu_start 1 cycle at cycle 1, rsp_valid=4'b0001 at cycle 8, rsp_data=15, rsp_err=0.
- Round-robin: req=4'b1111 held -> grants in order 0,1,2,3,0, each grant one-hot, with no overlapping pu_start and rsp_valid spacing of 9 cycles.
- Fairness after partial: req=4'b0101 with pointer starting at 0 -> order 0,2,0,2. Requester 1 asserting late is served before the next 0 repeat.
- Timeout: unit model never raises done -> rsp_valid after TIMEOUT cycles in WAIT with rsp_err=1 and rsp_data=0, then back in IDLE, busy=0.
- Reset mid-WAIT: rst_n low for 1 cycle at cycle 3 -> all outputs 0 next cycle, no rsp_valid. The new request launches only after pu_done has fallen.
- Relu/negative and stale done: the model returns 0 for a negative product -> rsp_data=0. pu_done is forced high while in IDLE with req pending -> no pu_start until pu_done=0.
